// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops one word from the TX FIFO and serialises it as
// start bit, LSB-first data, optional parity and one or two stop bits.
//
// state  | meaning
// IDLE   | line high, waiting for a non-empty FIFO
// FETCH  | pop strobe to the FIFO; read data lands on the closing edge
// LOAD   | capture word, compute parity, clear counters
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | optional parity bit
// STOP   | stop bit(s) (high); tx_done on the very last cycle
module uart_tx_engine #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        baud_cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    parity_bit;

    logic                    baud_wrap;
    logic [DATA_WIDTH-1:0]   shift_next;

    always_comb begin
        baud_wrap  = (baud_cnt == BAUD_LAST);
        shift_next = shift_reg >> 1;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        state      <= FETCH;
                        fifo_rd_en <= 1'b1;
                    end
                end

                FETCH: begin
                    tx    <= 1'b1;
                    state <= LOAD;
                end

                // tx is driven low here so the start bit is on the line for the full first START cycle
                LOAD: begin
                    shift_reg  <= fifo_dout;
                    parity_bit <= (^fifo_dout) ^ (PARITY_ODD != 0);
                    baud_cnt   <= '0;
                    bit_idx    <= '0;
                    tx         <= 1'b0;
                    state      <= START;
                end

                START: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_next;
                            tx        <= shift_next[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                // tx_done is registered, so it is raised one cycle ahead to coincide with the last stop cycle
                STOP: begin
                    tx <= 1'b1;
                    if (baud_cnt == BAUD_PRE && bit_idx == LAST_STOP) begin
                        tx_done <= 1'b1;
                    end
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: four instances (8N1, 8E1, 8O1, 8N2) at 4 clocks
// per bit, each fed by a small FIFO model and checked every cycle.
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] empty;
    logic [3:0] rd_en;
    logic [3:0] txv;
    logic [3:0] busyv;
    logic [3:0] donev;
    logic [7:0] dout [4];

    logic [7:0] mem [4][8];
    int rp [4] = '{0, 0, 0, 0};
    int wp [4] = '{0, 0, 0, 0};

    localparam int PEN [4] = '{0, 1, 1, 0};
    localparam int POD [4] = '{0, 0, 1, 0};
    localparam int PST [4] = '{1, 1, 1, 2};

    int tests = 0;
    int fails = 0;

    int         t      [4];
    int         mptr   [4];
    logic [7:0] mword  [4];
    int         rd_cnt [4];
    int         nf     [4];
    int         nd     [4];
    int         falls  [4][8];
    int         dones  [4][8];
    logic       armed  [4];
    logic       txlog  [4][2048];
    int         cyc = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(empty[0]), .fifo_dout(dout[0]),
        .fifo_rd_en(rd_en[0]), .tx(txv[0]), .busy(busyv[0]), .tx_done(donev[0]));
    uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(empty[1]), .fifo_dout(dout[1]),
        .fifo_rd_en(rd_en[1]), .tx(txv[1]), .busy(busyv[1]), .tx_done(donev[1]));
    uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(empty[2]), .fifo_dout(dout[2]),
        .fifo_rd_en(rd_en[2]), .tx(txv[2]), .busy(busyv[2]), .tx_done(donev[2]));
    uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(empty[3]), .fifo_dout(dout[3]),
        .fifo_rd_en(rd_en[3]), .tx(txv[3]), .busy(busyv[3]), .tx_done(donev[3]));

    assign empty[0] = (rp[0] == wp[0]);
    assign empty[1] = (rp[1] == wp[1]);
    assign empty[2] = (rp[2] == wp[2]);
    assign empty[3] = (rp[3] == wp[3]);

    // FIFO read data is registered on the edge that completes the pop
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rd_en[i]) begin
                dout[i] <= mem[i][rp[i] % 8];
                rp[i]   <= rp[i] + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d);
        mem[i][wp[i] % 8] = d;
        wp[i] = wp[i] + 1;
    endtask

    // Frame timeline: t=1 pop, t=2 load, t>=3 bit cells of 4 cycles each
    function automatic logic [3:0] model_out(input int i);
        int   len;
        int   b;
        logic bitv;
        if (t[i] < 0)  return 4'b1000;
        if (t[i] == 1) return 4'b1110;
        if (t[i] == 2) return 4'b1100;
        len = (9 + PEN[i] + PST[i]) * 4;
        b = (t[i] - 3) / 4;
        if (b == 0)                       bitv = 1'b0;
        else if (b <= 8)                  bitv = mword[i][b-1];
        else if (PEN[i] == 1 && b == 9)   bitv = (^mword[i]) ^ (POD[i] != 0);
        else                              bitv = 1'b1;
        return {bitv, 1'b1, 1'b0, (t[i] == 3 + len - 1)};
    endfunction

    function automatic int frame_len(input int i);
        return (9 + PEN[i] + PST[i]) * 4;
    endfunction

    function automatic logic sample(input int i, input int c);
        if (c < 0 || c >= 2048) return 1'bx;
        return txlog[i][c];
    endfunction

    function automatic int extract_byte(input int i, input int f);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = sample(i, f + 2 + 4 * (j + 1));
        return int'(b);
    endfunction

    initial begin
        logic [3:0] act;
        logic [3:0] exp;
        for (int i = 0; i < 4; i++) begin
            t[i] = -1; mptr[i] = 0; mword[i] = 8'h00; rd_cnt[i] = 0;
            nf[i] = 0; nd[i] = 0; armed[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                act = {txv[i], busyv[i], rd_en[i], donev[i]};
                if (!rst_n) begin
                    t[i] = -1;
                    exp = 4'b1000;
                end else begin
                    exp = model_out(i);
                end
                tests++;
                if (act !== exp) begin
                    fails++;
                    $display("FAIL cycle dut%0d cyc %0d: got %b expected %b (tx,busy,rd_en,done)", i, cyc, act, exp);
                end

                if (cyc < 2048) txlog[i][cyc] = txv[i];
                if (rd_en[i]) begin
                    rd_cnt[i]++;
                    armed[i] = 1'b1;
                end else if (armed[i] && !txv[i]) begin
                    if (nf[i] < 8) falls[i][nf[i]] = cyc;
                    nf[i]++;
                    armed[i] = 1'b0;
                end
                if (donev[i]) begin
                    if (nd[i] < 8) dones[i][nd[i]] = cyc;
                    nd[i]++;
                end

                if (rst_n) begin
                    if (t[i] < 0) begin
                        if (!empty[i]) begin
                            t[i] = 1;
                            mword[i] = mem[i][mptr[i] % 8];
                            mptr[i]++;
                        end
                    end else begin
                        t[i]++;
                        if (t[i] >= 3 + frame_len(i)) t[i] = -1;
                    end
                end
            end
            cyc++;
        end
    end

    initial begin
        int f;
        logic [9:0] bits;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Empty FIFO: nothing may happen for 100 cycles
        repeat (100) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("idle rd_en pulses dut%0d", i), rd_cnt[i], 0);
            chk($sformatf("idle done pulses dut%0d", i), nd[i], 0);
        end

        push(0, 8'hA5);
        push(1, 8'hA5);
        push(2, 8'h07);
        push(3, 8'h00);
        push(3, 8'hFF);
        push(3, 8'h3C);
        for (int k = 0; k < 400 && !(nd[0] == 1 && nd[1] == 1 && nd[2] == 1 && nd[3] == 3); k++)
            @(posedge clk);
        repeat (4) @(posedge clk);
        #1;

        // 8N1 0xA5: bit sequence 0,1,0,1,0,0,1,0,1,1
        f = falls[0][0];
        for (int k = 0; k < 10; k++) bits[k] = sample(0, f + 2 + 4 * k);
        chk("8n1 a5 bit sequence", int'(bits), 10'h34A);
        chk("8n1 rd_en pulses", rd_cnt[0], 1);
        chk("8n1 done pulses", nd[0], 1);
        chk("8n1 frame length", dones[0][0] - f + 1, 40);

        f = falls[1][0];
        chk("8e1 data", extract_byte(1, f), 8'hA5);
        chk("8e1 parity bit", int'(sample(1, f + 2 + 36)), 0);
        chk("8e1 frame length", dones[1][0] - f + 1, 44);

        f = falls[2][0];
        chk("8o1 data", extract_byte(2, f), 8'h07);
        chk("8o1 parity bit", int'(sample(2, f + 2 + 36)), 0);
        chk("8o1 frame length", dones[2][0] - f + 1, 44);

        chk("8n2 rd_en pulses", rd_cnt[3], 3);
        chk("8n2 done pulses", nd[3], 3);
        chk("8n2 data 0", extract_byte(3, falls[3][0]), 8'h00);
        chk("8n2 data 1", extract_byte(3, falls[3][1]), 8'hFF);
        chk("8n2 data 2", extract_byte(3, falls[3][2]), 8'h3C);
        for (int k = 0; k < 3; k++)
            chk($sformatf("8n2 frame %0d length", k), dones[3][k] - falls[3][k] + 1, 44);
        for (int k = 0; k < 2; k++)
            chk($sformatf("8n2 idle gap %0d", k), falls[3][k+1] - dones[3][k] - 1, 3);

        // Reset during data bit 3 of 0x55; 0xC3 must then go out intact
        push(0, 8'h55);
        push(0, 8'hC3);
        for (int k = 0; k < 50 && nf[0] < 2; k++) @(posedge clk);
        chk("0x55 frame started", nf[0], 2);
        repeat (16) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("reset tx high", int'(txv[0]), 1);
        chk("reset busy low", int'(busyv[0]), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 100 && nd[0] < 2; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("post-reset done pulses", nd[0], 2);
        chk("post-reset frame starts", nf[0], 3);
        chk("post-reset rd_en pulses", rd_cnt[0], 3);
        chk("post-reset data", extract_byte(0, falls[0][2]), 8'hC3);
        chk("post-reset stop bit", int'(sample(0, falls[0][2] + 2 + 36)), 1);
        chk("post-reset frame length", dones[0][1] - falls[0][2] + 1, 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
